// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory: word-organised little-endian array with byte/half/word
// loads and stores, sign/zero extension and a wait-state FSM that stalls the pipe.
module mem_stage_dmem #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ExMem_MemRead,
  input  logic        ExMem_MemWrite,
  input  logic [1:0]  ExMem_MemSize,
  input  logic        ExMem_MemSigned,
  input  logic [31:0] ExMem_AluResult,
  input  logic [31:0] ExMem_WriteData,
  output logic [31:0] DataMemory_ReadData,
  output logic        stall,
  output logic        misaligned
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES >= 2) ? 4'(WAIT_STATES - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;

  logic [31:0] mem [DEPTH_WORDS];

  logic             req, go, size_half, size_word;
  logic             stall_c, complete, commit;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word, rd_shift, rd_ext;
  logic [15:0]      rd_half;
  logic [7:0]       rd_byte;
  logic [31:0]      wr_lanes;
  logic [3:0]       wr_be;
  logic             unused_addr_hi;

  assign req        = ExMem_MemRead | ExMem_MemWrite;
  assign size_half  = (ExMem_MemSize == 2'b01);
  assign size_word  = ExMem_MemSize[1];
  assign misaligned = req & ((size_half & ExMem_AluResult[0]) |
                             (size_word & (ExMem_AluResult[1:0] != 2'b00)));
  assign go         = req & ~misaligned;

  // Upper address bits are deliberately dropped so addresses alias.
  assign idx            = ExMem_AluResult[IDX_W+1:2];
  assign unused_addr_hi = ^ExMem_AluResult[31:IDX_W+2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    stall_c  = 1'b0;
    complete = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          if (WAIT_STATES == 0) begin
            complete = 1'b1;
          end else if (WAIT_STATES == 1) begin
            stall_c = 1'b1;
            state_n = S_DONE;
          end else begin
            stall_c = 1'b1;
            state_n = S_WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        if (cnt == 4'd0) state_n = S_DONE;
        else             cnt_n   = cnt - 4'd1;
      end
      S_DONE: begin
        // Pipeline advances at the edge ending DONE, so always fall back to IDLE.
        complete = go;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign stall  = stall_c & ~reset;
  assign commit = complete & ExMem_MemWrite & ~reset;

  always_comb begin
    rd_word  = mem[idx];
    rd_shift = rd_word >> {ExMem_AluResult[1:0], 3'b000};
    rd_byte  = rd_shift[7:0];
    rd_half  = ExMem_AluResult[1] ? rd_word[31:16] : rd_word[15:0];
    case (ExMem_MemSize)
      2'b00:   rd_ext = {{24{ExMem_MemSigned & rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = {{16{ExMem_MemSigned & rd_half[15]}}, rd_half};
      default: rd_ext = rd_word;
    endcase
  end

  assign DataMemory_ReadData = (complete & ~ExMem_MemWrite & ~reset) ? rd_ext : '0;

  always_comb begin
    wr_lanes = ExMem_WriteData;
    wr_be    = 4'b1111;
    case (ExMem_MemSize)
      2'b00: begin
        wr_lanes = {4{ExMem_WriteData[7:0]}};
        wr_be    = 4'b0001 << ExMem_AluResult[1:0];
      end
      2'b01: begin
        wr_lanes = {2{ExMem_WriteData[15:0]}};
        wr_be    = ExMem_AluResult[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wr_lanes = ExMem_WriteData;
        wr_be    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Table-driven scoreboard bench for mem_stage_dmem at WAIT_STATES 2, 0 and 1.
module tb_mem_stage_dmem;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  rd = '0, wr = '0, sgn = '0;
  logic [1:0]  sz   [3];
  logic [31:0] addr [3];
  logic [31:0] wd   [3];
  logic [31:0] rdata [3];
  logic [2:0]  stl, mis;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_dmem #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut_ws2 (
    .clk(clk), .reset(reset), .ExMem_MemRead(rd[0]), .ExMem_MemWrite(wr[0]),
    .ExMem_MemSize(sz[0]), .ExMem_MemSigned(sgn[0]), .ExMem_AluResult(addr[0]),
    .ExMem_WriteData(wd[0]), .DataMemory_ReadData(rdata[0]), .stall(stl[0]),
    .misaligned(mis[0]));

  mem_stage_dmem #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .reset(reset), .ExMem_MemRead(rd[1]), .ExMem_MemWrite(wr[1]),
    .ExMem_MemSize(sz[1]), .ExMem_MemSigned(sgn[1]), .ExMem_AluResult(addr[1]),
    .ExMem_WriteData(wd[1]), .DataMemory_ReadData(rdata[1]), .stall(stl[1]),
    .misaligned(mis[1]));

  mem_stage_dmem #(.DEPTH_WORDS(256), .WAIT_STATES(1)) dut_ws1 (
    .clk(clk), .reset(reset), .ExMem_MemRead(rd[2]), .ExMem_MemWrite(wr[2]),
    .ExMem_MemSize(sz[2]), .ExMem_MemSigned(sgn[2]), .ExMem_AluResult(addr[2]),
    .ExMem_WriteData(wd[2]), .DataMemory_ReadData(rdata[2]), .stall(stl[2]),
    .misaligned(mis[2]));

  typedef struct {
    int          dut;
    logic        r, w;
    logic [1:0]  size;
    logic        s;
    logic [31:0] a, d;
    logic [31:0] exp_data;
    int          exp_stalls;
    logic        exp_mis;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          stalls;
    logic        mis;
    string       name;
  } exp_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  exp_t sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input int dut, input logic r, input logic w,
                              input logic [1:0] size, input logic s,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] exp_data, input int exp_stalls,
                              input logic exp_mis, input string name);
    vec_t v;
    v.dut = dut; v.r = r; v.w = w; v.size = size; v.s = s; v.a = a; v.d = d;
    v.exp_data = exp_data; v.exp_stalls = exp_stalls; v.exp_mis = exp_mis;
    v.name = name;
    return v;
  endfunction

  task automatic idle_all();
    rd = '0; wr = '0; sgn = '0;
    for (int i = 0; i < 3; i++) begin
      sz[i] = 2'b10; addr[i] = '0; wd[i] = '0;
    end
  endtask

  // Drive one access, push its expectation, count stall cycles, pop and compare.
  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n;
    bit   done;
    @(negedge clk);
    rd[v.dut] = v.r; wr[v.dut] = v.w; sz[v.dut] = v.size; sgn[v.dut] = v.s;
    addr[v.dut] = v.a; wd[v.dut] = v.d;
    sb_q.push_back('{v.exp_data, v.exp_stalls, v.exp_mis, v.name});
    n = 0;
    done = 1'b0;
    #2;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (stl[v.dut]) begin
        n++;
        @(negedge clk);
        #2;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout:%s actual=stall_stuck required=completion", v.name);
    end
    e = sb_q.pop_front();
    chk({"rdata:", e.name}, rdata[v.dut], e.data);
    chk({"stalls:", e.name}, 32'(n), 32'(e.stalls));
    chk({"mis:", e.name}, {31'd0, mis[v.dut]}, {31'd0, e.mis});
    @(posedge clk);
    #1;
    rd[v.dut] = 1'b0;
    wr[v.dut] = 1'b0;
  endtask

  initial begin
    idle_all();

    // dut 0: WAIT_STATES=2
    tbl_a.push_back(mk(0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 2, 0, "sw_10"));
    tbl_a.push_back(mk(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 2, 0, "lw_10"));
    tbl_a.push_back(mk(0, 0, 1, 2'b10, 0, 32'h20, 32'h8000F0A5, 32'h0, 2, 0, "sw_20"));
    tbl_a.push_back(mk(0, 1, 0, 2'b00, 1, 32'h20, 32'h0, 32'hFFFFFFA5, 2, 0, "lb_20"));
    tbl_a.push_back(mk(0, 1, 0, 2'b00, 0, 32'h20, 32'h0, 32'h000000A5, 2, 0, "lbu_20"));
    tbl_a.push_back(mk(0, 1, 0, 2'b01, 1, 32'h22, 32'h0, 32'hFFFF8000, 2, 0, "lh_22"));
    tbl_a.push_back(mk(0, 1, 0, 2'b01, 0, 32'h22, 32'h0, 32'h00008000, 2, 0, "lhu_22"));
    tbl_a.push_back(mk(0, 1, 0, 2'b00, 1, 32'h23, 32'h0, 32'hFFFFFF80, 2, 0, "lb_23"));
    tbl_a.push_back(mk(0, 0, 1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 2, 0, "sw_20b"));
    tbl_a.push_back(mk(0, 0, 1, 2'b00, 0, 32'h21, 32'hAABBCC77, 32'h0, 2, 0, "sb_21"));
    tbl_a.push_back(mk(0, 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h11227744, 2, 0, "lw_after_sb"));
    tbl_a.push_back(mk(0, 0, 1, 2'b01, 0, 32'h22, 32'h1234BEEF, 32'h0, 2, 0, "sh_22"));
    tbl_a.push_back(mk(0, 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'hBEEF7744, 2, 0, "lw_after_sh"));
    tbl_a.push_back(mk(0, 1, 0, 2'b10, 0, 32'h13, 32'h0, 32'h0, 0, 1, "lw_mis_13"));
    tbl_a.push_back(mk(0, 0, 1, 2'b10, 0, 32'h30, 32'h01020304, 32'h0, 2, 0, "sw_30"));
    tbl_a.push_back(mk(0, 0, 1, 2'b01, 0, 32'h31, 32'h0000FFFF, 32'h0, 0, 1, "sh_mis_31"));
    tbl_a.push_back(mk(0, 1, 0, 2'b10, 0, 32'h30, 32'h0, 32'h01020304, 2, 0, "lw_30"));
    tbl_a.push_back(mk(0, 0, 1, 2'b10, 0, 32'h40, 32'h00000005, 32'h0, 2, 0, "sw_40"));
    tbl_a.push_back(mk(0, 1, 1, 2'b10, 0, 32'h44, 32'hCAFEF00D, 32'h0, 2, 0, "rw_both_44"));
    tbl_a.push_back(mk(0, 1, 0, 2'b11, 0, 32'h44, 32'h0, 32'hCAFEF00D, 2, 0, "lw_size3_44"));
    tbl_a.push_back(mk(0, 1, 0, 2'b11, 0, 32'h46, 32'h0, 32'h0, 0, 1, "mis_size3_46"));
    tbl_a.push_back(mk(0, 0, 1, 2'b10, 0, 32'h410, 32'hA1A2A3A4, 32'h0, 2, 0, "sw_alias_410"));
    tbl_a.push_back(mk(0, 1, 0, 2'b10, 1, 32'h10, 32'h0, 32'hA1A2A3A4, 2, 0, "lw_alias_10"));
    // dut 1: WAIT_STATES=0
    tbl_a.push_back(mk(1, 0, 1, 2'b10, 0, 32'h8, 32'h13572468, 32'h0, 0, 0, "ws0_sw_8"));
    tbl_a.push_back(mk(1, 1, 0, 2'b10, 0, 32'h8, 32'h0, 32'h13572468, 0, 0, "ws0_lw_8"));
    tbl_a.push_back(mk(1, 1, 0, 2'b00, 1, 32'h9, 32'h0, 32'h00000024, 0, 0, "ws0_lb_9"));
    tbl_a.push_back(mk(1, 1, 0, 2'b01, 1, 32'hA, 32'h0, 32'h00001357, 0, 0, "ws0_lh_a"));
    // dut 2: WAIT_STATES=1
    tbl_a.push_back(mk(2, 0, 1, 2'b10, 0, 32'hC, 32'hF00FF00F, 32'h0, 1, 0, "ws1_sw_c"));
    tbl_a.push_back(mk(2, 1, 0, 2'b01, 0, 32'hE, 32'h0, 32'h0000F00F, 1, 0, "ws1_lhu_e"));
    tbl_a.push_back(mk(2, 1, 0, 2'b01, 1, 32'hE, 32'h0, 32'hFFFFF00F, 1, 0, "ws1_lh_e"));

    tbl_b.push_back(mk(0, 1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h00000005, 2, 0, "lw_40_after_rst"));
    tbl_b.push_back(mk(1, 1, 0, 2'b10, 0, 32'h8, 32'h0, 32'h13572468, 0, 0, "ws0_lw_after_rst"));

    // Reset state, including request behaviour while reset is held.
    repeat (2) @(negedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_stall%0d", i), {31'd0, stl[i]}, 32'd0);
      chk($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
      chk($sformatf("rst_mis%0d", i), {31'd0, mis[i]}, 32'd0);
    end
    rd[0] = 1'b1; sz[0] = 2'b10; addr[0] = 32'h13;
    #1;
    chk("rst_mis_follows", {31'd0, mis[0]}, 32'd1);
    addr[0] = 32'h10;
    #1;
    chk("rst_aligned_stall", {31'd0, stl[0]}, 32'd0);
    chk("rst_aligned_rdata", rdata[0], 32'd0);
    @(negedge clk);
    idle_all();
    reset = 1'b0;

    foreach (tbl_a[k]) run_vec(tbl_a[k]);

    // Reset while a store to 0x40 sits in WAIT: the old word must survive.
    @(negedge clk);
    wr[0] = 1'b1; sz[0] = 2'b10; addr[0] = 32'h40; wd[0] = 32'h00000099;
    @(negedge clk);
    #2;
    chk("wait_stall_before_rst", {31'd0, stl[0]}, 32'd1);
    reset = 1'b1;
    #1;
    chk("stall_during_rst", {31'd0, stl[0]}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr[0] = 1'b0;
    @(negedge clk);
    #2;
    chk("stall_after_rst", {31'd0, stl[0]}, 32'd0);
    chk("rdata_after_rst", rdata[0], 32'd0);

    // WAIT_STATES=0 store whose completion cycle has reset high is dropped.
    @(negedge clk);
    reset = 1'b1;
    wr[1] = 1'b1; sz[1] = 2'b10; addr[1] = 32'h8; wd[1] = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr[1] = 1'b0;

    foreach (tbl_b[k]) run_vec(tbl_b[k]);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
